// File: rtl/jtkcpu_pkg.sv
// ============================================================================
//  Module      : jtkcpu_pkg
//  Description : Shared constants and types for the jtkcpu interrupt logic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jtkcpu_pkg;

    // Vector index; the fetch address is 0xFFF0 + 2*index.
    localparam logic [2:0] VEC_RST  = 3'd7;
    localparam logic [2:0] VEC_NMI  = 3'd6;
    localparam logic [2:0] VEC_SWI  = 3'd5;
    localparam logic [2:0] VEC_IRQ  = 3'd4;
    localparam logic [2:0] VEC_FIRQ = 3'd3;
    localparam logic [2:0] VEC_SWI2 = 3'd2;
    localparam logic [2:0] VEC_SWI3 = 3'd1;

    localparam int CC_F = 6;
    localparam int CC_I = 4;

    typedef enum logic [2:0] {
        ST_RST_PEND = 3'd0,
        ST_IDLE     = 3'd1,
        ST_REQ      = 3'd2,
        ST_SYNC     = 3'd3,
        ST_CWAI     = 3'd4
    } int_state_t;

    function automatic logic [2:0] swi_vector(input logic [1:0] swi);
        case (swi)
            2'd1:    swi_vector = VEC_SWI;
            2'd2:    swi_vector = VEC_SWI2;
            default: swi_vector = VEC_SWI3;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/jtkcpu_intsync.sv
// ============================================================================
//  Module      : jtkcpu_intsync
//  Description : Pin synchroniser (free-running) plus cen-qualified fall detect.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtkcpu_intsync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_cen,
    input  logic i_pin,
    output logic o_level,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Pins idle high, so the chain resets to the deasserted level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev <= 1'b1;
        end else if (i_cen) begin
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_fall  = r_prev & ~r_sync[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/jtkcpu_intctl.sv
// ============================================================================
//  Module      : jtkcpu_intctl
//  Description : Interrupt/exception sequencer: NMI/FIRQ/IRQ/SWI, SYNC, CWAI.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtkcpu_intctl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       nmi,
    input  logic       firq,
    input  logic       irq,
    input  logic [7:0] cc,
    input  logic       up_s,
    input  logic       int_chk,
    input  logic [1:0] swi,
    input  logic       wait_sync,
    input  logic       wait_cwai,
    input  logic       int_ack,
    output logic       int_req,
    output logic [2:0] vector,
    output logic       push_all,
    output logic       set_i,
    output logic       set_f,
    output logic       sync_done
);

    import jtkcpu_pkg::*;

    // Pin index: 0 = NMI, 1 = FIRQ, 2 = IRQ
    logic [2:0] w_pins;
    logic [2:0] w_level;
    logic [2:0] w_fall;

    assign w_pins = {irq, firq, nmi};

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_sync
        jtkcpu_intsync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk     (clk),
            .rst     (rst),
            .i_cen   (cen),
            .i_pin   (w_pins[gi]),
            .o_level (w_level[gi]),
            .o_fall  (w_fall[gi])
        );
    end

    int_state_t r_state, w_state_nx;
    logic [2:0] r_vector, w_vector_nx;
    logic       r_push_all, w_push_nx;
    logic       r_set_i, w_set_i_nx;
    logic       r_set_f, w_set_f_nx;
    logic       r_sync_done, w_sync_done_nx;
    logic       r_nmi_armed, r_nmi_lat;

    logic       w_firq_p, w_irq_p;
    logic       w_chk_take, w_chk_push;
    logic [2:0] w_chk_vec;
    logic       w_async_take, w_async_firq;
    logic [2:0] w_async_vec;
    logic       w_any_low;
    logic       w_unused;

    assign w_firq_p  = ~w_level[1] & ~cc[CC_F];
    assign w_irq_p   = ~w_level[2] & ~cc[CC_I];
    assign w_any_low = ~&w_level | r_nmi_lat;
    assign w_unused  = ^{cc[7], cc[5], cc[3:0], w_fall[2:1]};

    // Boundary selection: NMI > SWI > FIRQ > IRQ
    always_comb begin
        w_chk_take = 1'b1;
        w_chk_push = 1'b1;
        w_chk_vec  = VEC_IRQ;
        if (r_nmi_lat) begin
            w_chk_vec = VEC_NMI;
        end else if (swi != 2'd0) begin
            w_chk_vec = swi_vector(swi);
        end else if (w_firq_p) begin
            w_chk_vec  = VEC_FIRQ;
            w_chk_push = 1'b0;
        end else if (!w_irq_p) begin
            w_chk_take = 1'b0;
        end
    end

    // Hardware-only selection used while parked in SYNC or CWAI
    always_comb begin
        w_async_take = 1'b1;
        w_async_firq = 1'b0;
        w_async_vec  = VEC_IRQ;
        if (r_nmi_lat) begin
            w_async_vec = VEC_NMI;
        end else if (w_firq_p) begin
            w_async_vec  = VEC_FIRQ;
            w_async_firq = 1'b1;
        end else if (!w_irq_p) begin
            w_async_take = 1'b0;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_vector_nx    = r_vector;
        w_push_nx      = r_push_all;
        w_set_i_nx     = 1'b0;
        w_set_f_nx     = 1'b0;
        w_sync_done_nx = 1'b0;
        case (r_state)
            ST_RST_PEND: begin
                if (int_ack) begin
                    w_state_nx = ST_IDLE;
                    w_set_i_nx = 1'b1;
                    w_set_f_nx = 1'b1;
                end
            end
            ST_IDLE: begin
                if (int_chk && w_chk_take) begin
                    w_state_nx  = ST_REQ;
                    w_vector_nx = w_chk_vec;
                    w_push_nx   = w_chk_push;
                end else if (wait_sync) begin
                    w_state_nx = ST_SYNC;
                end else if (wait_cwai) begin
                    w_state_nx = ST_CWAI;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    w_state_nx = ST_IDLE;
                    case (r_vector)
                        VEC_NMI, VEC_SWI, VEC_FIRQ: begin
                            w_set_i_nx = 1'b1;
                            w_set_f_nx = 1'b1;
                        end
                        VEC_IRQ: w_set_i_nx = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_SYNC: begin
                if (w_any_low) begin
                    if (w_async_take) begin
                        w_state_nx  = ST_REQ;
                        w_vector_nx = w_async_vec;
                        w_push_nx   = ~w_async_firq;
                    end else begin
                        w_state_nx     = ST_IDLE;
                        w_sync_done_nx = 1'b1;
                    end
                end
            end
            ST_CWAI: begin
                // Registers are already on the stack, so FIRQ also reports E=1.
                if (w_async_take) begin
                    w_state_nx  = ST_REQ;
                    w_vector_nx = w_async_vec;
                    w_push_nx   = 1'b1;
                end
            end
            default: w_state_nx = ST_RST_PEND;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_RST_PEND;
            r_vector    <= VEC_RST;
            r_push_all  <= 1'b0;
            r_set_i     <= 1'b0;
            r_set_f     <= 1'b0;
            r_sync_done <= 1'b0;
        end else if (cen) begin
            r_state     <= w_state_nx;
            r_vector    <= w_vector_nx;
            r_push_all  <= w_push_nx;
            r_set_i     <= w_set_i_nx;
            r_set_f     <= w_set_f_nx;
            r_sync_done <= w_sync_done_nx;
        end
    end

    // A fresh edge wins over the acknowledge clearing the previous one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_nmi_armed <= 1'b0;
            r_nmi_lat   <= 1'b0;
        end else if (cen) begin
            if (up_s) begin
                r_nmi_armed <= 1'b1;
            end
            if (w_fall[0] && r_nmi_armed) begin
                r_nmi_lat <= 1'b1;
            end else if (r_state == ST_REQ && int_ack && r_vector == VEC_NMI) begin
                r_nmi_lat <= 1'b0;
            end
        end
    end

    assign int_req   = (r_state == ST_REQ) || (r_state == ST_RST_PEND);
    assign vector    = r_vector;
    assign push_all  = r_push_all;
    assign set_i     = r_set_i;
    assign set_f     = r_set_f;
    assign sync_done = r_sync_done;

endmodule

`default_nettype wire

// File: tb/tb_jtkcpu_intctl.sv
// ============================================================================
//  Module      : tb_jtkcpu_intctl
//  Description : Directed vector-table bench for jtkcpu_intctl.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jtkcpu_intctl;

    typedef struct {
        logic [2:0] pins;   // {nmi, firq, irq}
        logic [7:0] cc;
        logic [4:0] ctl;    // {up_s, int_chk, wait_sync, wait_cwai, int_ack}
        logic [1:0] swi;
        logic [7:0] exp;    // {int_req, vector[2:0], push_all, set_i, set_f, sync_done}
        logic [7:0] mask;
    } vec_t;

    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_UPS  = 5'b10000;
    localparam logic [4:0] C_CHK  = 5'b01000;
    localparam logic [4:0] C_SYNC = 5'b00100;
    localparam logic [4:0] C_CWAI = 5'b00010;
    localparam logic [4:0] C_ACK  = 5'b00001;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cen = 1'b1;
    logic       nmi = 1'b1, firq = 1'b1, irq = 1'b1;
    logic [7:0] cc = 8'h50;
    logic       up_s = 1'b0, int_chk = 1'b0;
    logic [1:0] swi = 2'd0;
    logic       wait_sync = 1'b0, wait_cwai = 1'b0, int_ack = 1'b0;
    logic       int_req, push_all, set_i, set_f, sync_done;
    logic [2:0] vector;

    int n_pass  = 0;
    int n_total = 0;
    vec_t tbl[$];

    jtkcpu_intctl #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .nmi       (nmi),
        .firq      (firq),
        .irq       (irq),
        .cc        (cc),
        .up_s      (up_s),
        .int_chk   (int_chk),
        .swi       (swi),
        .wait_sync (wait_sync),
        .wait_cwai (wait_cwai),
        .int_ack   (int_ack),
        .int_req   (int_req),
        .vector    (vector),
        .push_all  (push_all),
        .set_i     (set_i),
        .set_f     (set_f),
        .sync_done (sync_done)
    );

    always #5 clk = ~clk;

    // v < 0 marks vector/push_all as don't-care
    function automatic vec_t mk(input logic [2:0] pins, input logic [7:0] ccv,
                                input logic [4:0] ctl, input logic [1:0] sw,
                                input logic req, input int v, input logic push,
                                input logic [2:0] strb);
        vec_t r;
        r.pins = pins;
        r.cc   = ccv;
        r.ctl  = ctl;
        r.swi  = sw;
        r.exp  = {req, (v < 0) ? 3'd0 : 3'(v), push, strb};
        r.mask = (v < 0) ? 8'h87 : 8'hFF;
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] exp, input logic [7:0] mask);
        logic [7:0] act;
        act = {int_req, vector, push_all, set_i, set_f, sync_done};
        n_total++;
        if (((act ^ exp) & mask) == 8'h00)
            n_pass++;
        else
            $display("FAIL %s: got req/vec/push/si/sf/sd=%b, want %b (mask %b)",
                     name, act, exp, mask);
    endtask

    task automatic apply(input vec_t r, input int idx);
        {nmi, firq, irq} = r.pins;
        cc = r.cc;
        {up_s, int_chk, wait_sync, wait_cwai, int_ack} = r.ctl;
        swi = r.swi;
        @(posedge clk);
        #1;
        check($sformatf("row%0d", idx), r.exp, r.mask);
    endtask

    initial begin
        // reset release and ack
        tbl.push_back(mk(3'b111, 8'h50, C_NONE, 2'd0, 1'b1,  7, 1'b0, 3'b000)); // 0
        tbl.push_back(mk(3'b111, 8'h50, C_ACK,  2'd0, 1'b0, -1, 1'b0, 3'b110)); // 1
        tbl.push_back(mk(3'b111, 8'h50, C_NONE, 2'd0, 1'b0, -1, 1'b0, 3'b000)); // 2
        // NMI edge while unarmed is dropped
        tbl.push_back(mk(3'b011, 8'h50, C_NONE, 2'd0, 1'b0, -1, 1'b0, 3'b000)); // 3
        tbl.push_back(mk(3'b011, 8'h50, C_NONE, 2'd0, 1'b0, -1, 1'b0, 3'b000)); // 4
        tbl.push_back(mk(3'b011, 8'h50, C_NONE, 2'd0, 1'b0, -1, 1'b0, 3'b000)); // 5
        tbl.push_back(mk(3'b111, 8'h50, C_NONE, 2'd0, 1'b0, -1, 1'b0, 3'b000)); // 6
        tbl.push_back(mk(3'b111, 8'h50, C_CHK,  2'd0, 1'b0, -1, 1'b0, 3'b000)); // 7
        // arm, then a real NMI edge
        tbl.push_back(mk(3'b111, 8'h50, C_UPS,  2'd0, 1'b0, -1, 1'b0, 3'b000)); // 8
        tbl.push_back(mk(3'b011, 8'h50, C_NONE, 2'd0, 1'b0, -1, 1'b0, 3'b000)); // 9
        tbl.push_back(mk(3'b011, 8'h50, C_NONE, 2'd0, 1'b0, -1, 1'b0, 3'b000)); // 10
        tbl.push_back(mk(3'b011, 8'h50, C_NONE, 2'd0, 1'b0, -1, 1'b0, 3'b000)); // 11
        tbl.push_back(mk(3'b111, 8'h50, C_CHK,  2'd0, 1'b1,  6, 1'b1, 3'b000)); // 12
        tbl.push_back(mk(3'b111, 8'h50, C_NONE, 2'd0, 1'b1,  6, 1'b1, 3'b000)); // 13
        tbl.push_back(mk(3'b111, 8'h50, C_ACK,  2'd0, 1'b0, -1, 1'b0, 3'b110)); // 14
        tbl.push_back(mk(3'b111, 8'h50, C_NONE, 2'd0, 1'b0, -1, 1'b0, 3'b000)); // 15
        tbl.push_back(mk(3'b111, 8'h50, C_CHK,  2'd0, 1'b0, -1, 1'b0, 3'b000)); // 16
        // FIRQ over IRQ, then IRQ with F masked
        tbl.push_back(mk(3'b100, 8'h00, C_NONE, 2'd0, 1'b0, -1, 1'b0, 3'b000)); // 17
        tbl.push_back(mk(3'b100, 8'h00, C_NONE, 2'd0, 1'b0, -1, 1'b0, 3'b000)); // 18
        tbl.push_back(mk(3'b100, 8'h00, C_CHK,  2'd0, 1'b1,  3, 1'b0, 3'b000)); // 19
        tbl.push_back(mk(3'b100, 8'h00, C_ACK,  2'd0, 1'b0, -1, 1'b0, 3'b110)); // 20
        tbl.push_back(mk(3'b100, 8'h40, C_CHK,  2'd0, 1'b1,  4, 1'b1, 3'b000)); // 21
        tbl.push_back(mk(3'b100, 8'h40, C_ACK,  2'd0, 1'b0, -1, 1'b0, 3'b100)); // 22
        // SWI2 beats IRQ and leaves masks alone
        tbl.push_back(mk(3'b110, 8'h40, C_CHK,  2'd2, 1'b1,  2, 1'b1, 3'b000)); // 23
        tbl.push_back(mk(3'b110, 8'h40, C_ACK,  2'd0, 1'b0, -1, 1'b0, 3'b000)); // 24
        // NMI beats SWI, then plain SWI
        tbl.push_back(mk(3'b011, 8'h50, C_NONE, 2'd0, 1'b0, -1, 1'b0, 3'b000)); // 25
        tbl.push_back(mk(3'b011, 8'h50, C_NONE, 2'd0, 1'b0, -1, 1'b0, 3'b000)); // 26
        tbl.push_back(mk(3'b011, 8'h50, C_NONE, 2'd0, 1'b0, -1, 1'b0, 3'b000)); // 27
        tbl.push_back(mk(3'b111, 8'h50, C_CHK,  2'd1, 1'b1,  6, 1'b1, 3'b000)); // 28
        tbl.push_back(mk(3'b111, 8'h50, C_ACK,  2'd0, 1'b0, -1, 1'b0, 3'b110)); // 29
        tbl.push_back(mk(3'b111, 8'h50, C_CHK,  2'd1, 1'b1,  5, 1'b1, 3'b000)); // 30
        tbl.push_back(mk(3'b111, 8'h50, C_ACK,  2'd0, 1'b0, -1, 1'b0, 3'b110)); // 31
        // SYNC released by a masked IRQ
        tbl.push_back(mk(3'b111, 8'h50, C_SYNC, 2'd0, 1'b0, -1, 1'b0, 3'b000)); // 32
        tbl.push_back(mk(3'b110, 8'h50, C_NONE, 2'd0, 1'b0, -1, 1'b0, 3'b000)); // 33
        tbl.push_back(mk(3'b110, 8'h50, C_NONE, 2'd0, 1'b0, -1, 1'b0, 3'b000)); // 34
        tbl.push_back(mk(3'b110, 8'h50, C_NONE, 2'd0, 1'b0, -1, 1'b0, 3'b001)); // 35
        tbl.push_back(mk(3'b111, 8'h50, C_NONE, 2'd0, 1'b0, -1, 1'b0, 3'b000)); // 36
        tbl.push_back(mk(3'b111, 8'h50, C_NONE, 2'd0, 1'b0, -1, 1'b0, 3'b000)); // 37
        tbl.push_back(mk(3'b111, 8'h50, C_NONE, 2'd0, 1'b0, -1, 1'b0, 3'b000)); // 38
        // CWAI taken by FIRQ stacks everything
        tbl.push_back(mk(3'b111, 8'h00, C_CWAI, 2'd0, 1'b0, -1, 1'b0, 3'b000)); // 39
        tbl.push_back(mk(3'b101, 8'h00, C_NONE, 2'd0, 1'b0, -1, 1'b0, 3'b000)); // 40
        tbl.push_back(mk(3'b101, 8'h00, C_NONE, 2'd0, 1'b0, -1, 1'b0, 3'b000)); // 41
        tbl.push_back(mk(3'b101, 8'h00, C_NONE, 2'd0, 1'b1,  3, 1'b1, 3'b000)); // 42
        tbl.push_back(mk(3'b101, 8'h00, C_ACK,  2'd0, 1'b0, -1, 1'b0, 3'b110)); // 43
        tbl.push_back(mk(3'b111, 8'h50, C_NONE, 2'd0, 1'b0, -1, 1'b0, 3'b000)); // 44
        // park in an IRQ request for the hand-written sequences
        tbl.push_back(mk(3'b110, 8'h40, C_NONE, 2'd0, 1'b0, -1, 1'b0, 3'b000)); // 45
        tbl.push_back(mk(3'b110, 8'h40, C_NONE, 2'd0, 1'b0, -1, 1'b0, 3'b000)); // 46
        tbl.push_back(mk(3'b110, 8'h40, C_CHK,  2'd0, 1'b1,  4, 1'b1, 3'b000)); // 47

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {1'b1, 3'd7, 1'b0, 3'b000}, 8'hFF);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], i);

        // ack with cen low must be ignored
        {up_s, int_chk, wait_sync, wait_cwai} = 4'b0000;
        swi = 2'd0;
        cen = 1'b0;
        int_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("cen0_hold", {1'b1, 3'd4, 1'b1, 3'b000}, 8'hFF);

        // asynchronous reset in the middle of REQ
        int_ack = 1'b0;
        cen = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("async_rst", {1'b1, 3'd7, 1'b0, 3'b000}, 8'hFF);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release", {1'b1, 3'd7, 1'b0, 3'b000}, 8'hFF);
        int_ack = 1'b1;
        @(posedge clk);
        #1;
        int_ack = 1'b0;
        check("rst_ack", {1'b0, 3'd0, 1'b0, 3'b110}, 8'h87);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
